// File: rtl/mem_fill_ctrl.sv
// mem_fill_ctrl: streams cfg_words words per tile from a 1-cycle-latency SRAM into the
// compute input buffer, and runs the PREP/WAIT/COMP handshake with the compute-side FSM.
module mem_fill_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8,
  parameter int TILE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clear,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [CNT_W-1:0]  cfg_words,
  input  logic [TILE_W-1:0] cfg_tiles,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              buf_wr_en,
  output logic [CNT_W-1:0]  buf_wr_addr,
  output logic [DATA_W-1:0] buf_wr_data,
  output logic              prep_done,
  output logic              tile_ready,
  input  logic              comp_done,
  output logic              busy,
  output logic              all_done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PREP  = 3'd1;
  localparam logic [2:0] S_FILL  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_HAND  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_words;
  logic [TILE_W-1:0] r_tiles;
  logic [TILE_W-1:0] r_tile_idx;
  logic [CNT_W-1:0]  r_word_idx;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_buf_wr_en;
  logic [CNT_W-1:0]  r_buf_wr_addr;
  logic              r_prep_done;
  logic              r_tile_ready;
  logic              r_all_done;
  logic              r_busy;

  logic w_last_word;
  logic w_last_tile;
  logic w_cfg_empty;

  assign w_last_word = (r_word_idx == (r_words - CNT_W'(1)));
  assign w_last_tile = (r_tile_idx == (r_tiles - TILE_W'(1)));
  assign w_cfg_empty = (cfg_words == '0) || (cfg_tiles == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_base        <= '0;
      r_words       <= '0;
      r_tiles       <= '0;
      r_tile_idx    <= '0;
      r_word_idx    <= '0;
      r_rd_en       <= 1'b0;
      r_rd_addr     <= '0;
      r_buf_wr_en   <= 1'b0;
      r_buf_wr_addr <= '0;
      r_prep_done   <= 1'b0;
      r_tile_ready  <= 1'b0;
      r_all_done    <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_prep_done   <= 1'b0;
      r_tile_ready  <= 1'b0;
      r_all_done    <= 1'b0;
      // The buffer write trails the SRAM read by exactly its 1-cycle latency.
      r_buf_wr_en   <= r_rd_en;
      r_buf_wr_addr <= r_word_idx;
      if (clear) begin
        r_state     <= S_IDLE;
        r_rd_en     <= 1'b0;
        r_buf_wr_en <= 1'b0;
        r_busy      <= 1'b0;
        r_word_idx  <= '0;
        r_tile_idx  <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_base  <= cfg_base;
              r_words <= cfg_words;
              r_tiles <= cfg_tiles;
              r_busy  <= 1'b1;
              if (w_cfg_empty) begin
                r_state    <= S_DONE;
                r_all_done <= 1'b1;
              end else begin
                r_state     <= S_PREP;
                r_prep_done <= 1'b1;
              end
            end
          end
          S_PREP: begin
            r_state    <= S_FILL;
            r_rd_en    <= 1'b1;
            r_rd_addr  <= r_base;
            r_word_idx <= '0;
            r_tile_idx <= '0;
          end
          S_FILL: begin
            // Pointer advances on every read so the next tile continues where this one ended.
            r_rd_addr <= r_rd_addr + ADDR_W'(1);
            if (w_last_word) begin
              r_state <= S_DRAIN;
              r_rd_en <= 1'b0;
            end else begin
              r_word_idx <= r_word_idx + CNT_W'(1);
            end
          end
          S_DRAIN: begin
            r_state      <= S_HAND;
            r_tile_ready <= 1'b1;
          end
          S_HAND: begin
            if (comp_done) begin
              if (w_last_tile) begin
                r_state    <= S_DONE;
                r_all_done <= 1'b1;
              end else begin
                r_state    <= S_FILL;
                r_tile_idx <= r_tile_idx + TILE_W'(1);
                r_word_idx <= '0;
                r_rd_en    <= 1'b1;
              end
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_rd_en <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rd_en       = r_rd_en;
  assign rd_addr     = r_rd_addr;
  assign buf_wr_en   = r_buf_wr_en;
  assign buf_wr_addr = r_buf_wr_addr;
  // SRAM output is already registered; gated so the port stays quiet outside write cycles.
  assign buf_wr_data = r_buf_wr_en ? rd_data : '0;
  assign prep_done   = r_prep_done;
  assign tile_ready  = r_tile_ready;
  assign all_done    = r_all_done;
  assign busy        = r_busy;

endmodule

// File: tb/tb_mem_fill_ctrl.sv
// tb_mem_fill_ctrl: randomized jobs checked against an address/latency model of the
// fill controller; scenario tasks cover reset, wrap, empty jobs, held comp_done, clear.
module tb_mem_fill_ctrl;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int CW = 8;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic          comp_done = 1'b0;
  logic [AW-1:0] cfg_base = '0;
  logic [CW-1:0] cfg_words = '0;
  logic [TW-1:0] cfg_tiles = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic          buf_wr_en;
  logic [CW-1:0] buf_wr_addr;
  logic [DW-1:0] buf_wr_data;
  logic          prep_done;
  logic          tile_ready;
  logic          busy;
  logic          all_done;

  logic [DW-1:0] mem [1024];
  int n_chk = 0;
  int n_pass = 0;

  mem_fill_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .TILE_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .cfg_base(cfg_base), .cfg_words(cfg_words), .cfg_tiles(cfg_tiles),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
    .prep_done(prep_done), .tile_ready(tile_ready), .comp_done(comp_done),
    .busy(busy), .all_done(all_done)
  );

  always #5 clk = ~clk;

  // SRAM model with a fixed 1-cycle read latency.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want job completion");
    $fatal(1, "watchdog");
  end

  // mode 0: random comp_done delay plus noise outside HAND
  // mode 1: comp_done held high throughout
  // mode 2: as mode 0, plus start pulses and cfg changes while busy
  task automatic run_job(input logic [AW-1:0] base, input logic [CW-1:0] words,
                         input logic [TW-1:0] tiles, input int mode);
    int total, bound, cyc, nrd, nwr, npd, ntr, nad;
    int acc_cyc, fill_cyc, done_cyc, last_rd, tiles_acc, wexp, dexp;
    bit empty, in_hand, finished;
    int rd_cyc[$];
    logic [AW-1:0] a;
    empty = (words == '0) || (tiles == '0);
    total = empty ? 0 : int'(words) * int'(tiles);
    bound = total + int'(tiles) * 16 + 20;
    nrd = 0; nwr = 0; npd = 0; ntr = 0; nad = 0; cyc = 0;
    acc_cyc = -1; fill_cyc = -1; done_cyc = -1; last_rd = -100; tiles_acc = 0;
    in_hand = 1'b0; finished = 1'b0;
    @(negedge clk);
    start = 1'b1; cfg_base = base; cfg_words = words; cfg_tiles = tiles;
    comp_done = (mode == 1);
    while (!finished && cyc < bound) begin
      @(negedge clk);
      cyc++;
      if (prep_done) begin
        npd++;
        n_chk++;
        if (cyc != 1) $display("FAIL prep_done_cycle: got %0d want 1", cyc);
        else n_pass++;
      end
      if (cyc == fill_cyc) begin
        n_chk++;
        if (rd_en !== 1'b1) $display("FAIL refill_latency: rd_en got %b want 1 at cycle %0d", rd_en, cyc);
        else n_pass++;
      end
      if (rd_en) begin
        a = base + AW'(nrd);
        n_chk++;
        if (rd_addr !== a || nrd >= total)
          $display("FAIL rd_addr[%0d]: got %h want %h (reads expected %0d)", nrd, rd_addr, a, total);
        else n_pass++;
        if (nrd == 0) begin
          n_chk++;
          if (cyc != 2) $display("FAIL first_read_cycle: got %0d want 2", cyc);
          else n_pass++;
        end
        rd_cyc.push_back(cyc);
        last_rd = cyc;
        nrd++;
      end
      if (buf_wr_en) begin
        a = base + AW'(nwr);
        wexp = (words == '0) ? 0 : nwr % int'(words);
        n_chk++;
        if (nwr >= rd_cyc.size() || cyc != rd_cyc[nwr] + 1 ||
            buf_wr_addr !== CW'(wexp) || buf_wr_data !== mem[a])
          $display("FAIL buf_write[%0d]: got addr %0d data %h cyc %0d want addr %0d data %h",
                   nwr, buf_wr_addr, buf_wr_data, cyc, wexp, mem[a]);
        else n_pass++;
        nwr++;
      end
      if (tile_ready) begin
        n_chk++;
        if (cyc != last_rd + 2 || nrd != (ntr + 1) * int'(words) || in_hand)
          $display("FAIL tile_ready[%0d]: got cycle %0d reads %0d want cycle %0d reads %0d",
                   ntr, cyc, nrd, last_rd + 2, (ntr + 1) * int'(words));
        else n_pass++;
        ntr++;
        in_hand = 1'b1;
      end
      if (all_done) begin
        dexp = empty ? 1 : acc_cyc + 1;
        n_chk++;
        if (cyc != dexp || nad != 0 || ntr != (empty ? 0 : int'(tiles)))
          $display("FAIL all_done: got cycle %0d tiles %0d want cycle %0d tiles %0d",
                   cyc, ntr, dexp, empty ? 0 : int'(tiles));
        else n_pass++;
        nad++;
        done_cyc = cyc;
      end
      n_chk++;
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        if (busy !== 1'b0) $display("FAIL busy_after_done: got %b want 0", busy);
        else n_pass++;
        finished = 1'b1;
      end else begin
        if (busy !== 1'b1) $display("FAIL busy_in_job: got %b want 1 at cycle %0d", busy, cyc);
        else n_pass++;
      end
      // drive the inputs for the next rising edge
      if (mode == 2 && !finished) begin
        start     = 1'($urandom_range(0, 1));
        cfg_base  = AW'($urandom);
        cfg_words = CW'($urandom_range(0, 9));
        cfg_tiles = TW'($urandom_range(0, 4));
      end else begin
        start = 1'b0;
      end
      if (finished) begin
        comp_done = 1'b0;
      end else if (in_hand) begin
        if (mode == 1 || $urandom_range(0, 2) == 0) begin
          comp_done = 1'b1;
          in_hand = 1'b0;
          acc_cyc = cyc;
          tiles_acc++;
          if (tiles_acc < int'(tiles)) fill_cyc = cyc + 1;
        end else begin
          comp_done = 1'b0;
        end
      end else begin
        comp_done = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      end
    end
    start = 1'b0;
    comp_done = 1'b0;
    n_chk++;
    if (!finished) $display("FAIL job_timeout: got no completion in %0d cycles want all_done", bound);
    else n_pass++;
    n_chk++;
    if (nrd != total || nwr != total)
      $display("FAIL transfer_count: got reads %0d writes %0d want %0d", nrd, nwr, total);
    else n_pass++;
    n_chk++;
    if (npd != (empty ? 0 : 1)) $display("FAIL prep_done_count: got %0d want %0d", npd, empty ? 0 : 1);
    else n_pass++;
    n_chk++;
    if (nad != 1) $display("FAIL all_done_count: got %0d want 1", nad);
    else n_pass++;
    $display("job base=%h words=%0d tiles=%0d mode=%0d reads=%0d writes=%0d tiles_done=%0d",
             base, words, tiles, mode, nrd, nwr, ntr);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++;
    if ({rd_en, buf_wr_en, prep_done, tile_ready, busy, all_done} !== 6'b0 ||
        rd_addr !== '0 || buf_wr_addr !== '0 || buf_wr_data !== '0)
      $display("FAIL reset_outputs: got flags %b rd_addr %h wr_addr %h want all 0",
               {rd_en, buf_wr_en, prep_done, tile_ready, busy, all_done}, rd_addr, buf_wr_addr);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({rd_en, buf_wr_en, prep_done, tile_ready, busy, all_done} !== 6'b0)
      $display("FAIL idle_after_reset: got %b want 000000",
               {rd_en, buf_wr_en, prep_done, tile_ready, busy, all_done});
    else n_pass++;
    $display("reset released");
  endtask

  task automatic test_basic();
    run_job(10'h010, 8'd4, 8'd1, 0);
  endtask

  task automatic test_wrap();
    run_job(10'h3FE, 8'd4, 8'd2, 0);
  endtask

  task automatic test_empty();
    run_job(10'h055, 8'd0, 8'd3, 0);
    run_job(10'h155, 8'd5, 8'd0, 0);
  endtask

  task automatic test_comp_held();
    run_job(10'h2A0, 8'd3, 8'd3, 1);
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 8; j++)
      run_job(AW'($urandom), CW'($urandom_range(1, 6)), TW'($urandom_range(1, 3)), 2);
  endtask

  task automatic test_clear();
    bit quiet;
    @(negedge clk);
    start = 1'b1; cfg_base = 10'h123; cfg_words = 8'd5; cfg_tiles = 8'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (rd_en !== 1'b1 || rd_addr !== 10'h124)
      $display("FAIL clear_setup: got rd_en %b addr %h want 1 124", rd_en, rd_addr);
    else n_pass++;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    n_chk++;
    if (rd_en !== 1'b0 || buf_wr_en !== 1'b0 || busy !== 1'b0)
      $display("FAIL clear_abort: got rd_en %b wr_en %b busy %b want 0 0 0", rd_en, buf_wr_en, busy);
    else n_pass++;
    quiet = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rd_en || buf_wr_en || tile_ready || all_done || prep_done || busy) quiet = 1'b0;
    end
    n_chk++;
    if (!quiet) $display("FAIL clear_quiet: got activity after clear want none");
    else n_pass++;
    $display("clear issued on second fill cycle");
    run_job(10'h123, 8'd5, 8'd2, 0);
  endtask

  task automatic test_reset_midjob();
    bit seen, quiet;
    @(negedge clk);
    start = 1'b1; cfg_base = 10'h200; cfg_words = 8'd3; cfg_tiles = 8'd2; comp_done = 1'b0;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (tile_ready) seen = 1'b1;
    end
    n_chk++;
    if (!seen) $display("FAIL reset_setup: got no tile_ready want one within 30 cycles");
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({rd_en, buf_wr_en, prep_done, tile_ready, busy, all_done} !== 6'b0 ||
        rd_addr !== '0 || buf_wr_addr !== '0)
      $display("FAIL async_reset: got flags %b rd_addr %h want all 0",
               {rd_en, buf_wr_en, prep_done, tile_ready, busy, all_done}, rd_addr);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (rd_en || buf_wr_en || tile_ready || all_done || prep_done || busy) quiet = 1'b0;
    end
    n_chk++;
    if (!quiet) $display("FAIL reset_quiet: got activity after reset want none");
    else n_pass++;
    $display("reset asserted in HAND and released");
    run_job(10'h200, 8'd3, 8'd2, 2);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = DW'($urandom);
    test_reset();
    test_basic();
    test_wrap();
    test_empty();
    test_comp_held();
    test_back_to_back();
    test_clear();
    test_reset_midjob();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
